// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types and frame geometry for the capture-to-DCT path
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_DCT_START = 3'd2,
    ST_DCT_WAIT  = 3'd3,
    ST_STREAM    = 3'd4
  } sched_state_t;

  localparam int MCUS_PER_STRIP   = 28;
  localparam int STRIPS_PER_FRAME = 28;
  localparam int COEFS_PER_MCU    = 64;
  localparam int CAPTURE_X0       = 208;
  localparam int CAPTURE_Y0       = 128;

endpackage

// File: rtl/strip_dct_scheduler_coef_streamer.sv
// rtl/strip_dct_scheduler_coef_streamer.sv - coefficient index counter with valid/ready, last flag and MCU done pulse
module coef_streamer #(
  parameter int NUM_COEFS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic       ready_i,
  output logic [5:0] idx_o,
  output logic       last_o,
  output logic       done_o
);

  logic [5:0] idx_q;
  logic [5:0] idx_d;
  logic       accept;

  assign accept = valid_i && ready_i;
  assign last_o = (idx_q == 6'(NUM_COEFS - 1));
  assign done_o = accept && last_o;
  assign idx_o  = idx_q;

  // Acceptance of the final coefficient rewinds the index for the next MCU.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = 6'd0;
    end else if (done_o) begin
      idx_d = 6'd0;
    end else if (accept) begin
      idx_d = idx_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 6'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/strip_dct_scheduler.sv
// rtl/strip_dct_scheduler.sv - strip capture / DCT / coefficient stream sequencer for one frame
module strip_dct_scheduler
  import jpeg_pkg::*;
#(
  parameter int NUM_MCUS   = MCUS_PER_STRIP,
  parameter int NUM_STRIPS = STRIPS_PER_FRAME,
  parameter int NUM_COEFS  = COEFS_PER_MCU,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              strip_ready,
  output logic              capture_en,
  output logic [4:0]        strip_number,
  output logic [4:0]        mcu_sel,
  output logic              dct_start,
  input  logic              dct_done,
  output logic [5:0]        coef_idx,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  sched_state_t state_q, state_d;
  logic [4:0]   strip_q, strip_d;
  logic [4:0]   mcu_q, mcu_d;
  logic         overrun_q, overrun_d;
  logic         frame_done_q, frame_done_d;

  logic stream_active;
  logic coef_clear;
  logic coef_last;
  logic mcu_done;
  logic last_mcu;
  logic last_strip;

  assign last_mcu      = (mcu_q == 5'(NUM_MCUS - 1));
  assign last_strip    = (strip_q == 5'(NUM_STRIPS - 1));
  assign stream_active = (state_q == ST_STREAM);
  assign coef_clear    = abort || ((state_q == ST_IDLE) && start);

  coef_streamer #(
    .NUM_COEFS (NUM_COEFS)
  ) u_coef_streamer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (coef_clear),
    .valid_i (stream_active),
    .ready_i (out_ready),
    .idx_o   (coef_idx),
    .last_o  (coef_last),
    .done_o  (mcu_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      strip_q      <= 5'd0;
      mcu_q        <= 5'd0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      strip_q      <= strip_d;
      mcu_q        <= mcu_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // abort outranks every other event, including a coincident start or strip_ready.
  always_comb begin
    state_d      = state_q;
    strip_d      = strip_q;
    mcu_d        = mcu_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q || (strip_ready && (state_q != ST_CAPTURE));
    if (abort) begin
      state_d = ST_IDLE;
      strip_d = 5'd0;
      mcu_d   = 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_CAPTURE;
            strip_d   = 5'd0;
            mcu_d     = 5'd0;
            overrun_d = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (strip_ready) begin
            state_d = ST_DCT_START;
          end
        end
        ST_DCT_START: begin
          state_d = ST_DCT_WAIT;
        end
        ST_DCT_WAIT: begin
          if (dct_done) begin
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (mcu_done) begin
            if (!last_mcu) begin
              mcu_d   = mcu_q + 5'd1;
              state_d = ST_DCT_START;
            end else if (!last_strip) begin
              strip_d = strip_q + 5'd1;
              mcu_d   = 5'd0;
              state_d = ST_CAPTURE;
            end else begin
              strip_d      = 5'd0;
              mcu_d        = 5'd0;
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          strip_d = 5'd0;
          mcu_d   = 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    capture_en   = (state_q == ST_CAPTURE);
    dct_start    = (state_q == ST_DCT_START);
    out_valid    = stream_active;
    out_last     = stream_active && coef_last;
    out_eof      = stream_active && coef_last && last_mcu && last_strip;
    busy         = (state_q != ST_IDLE);
    frame_done   = frame_done_q;
    overrun      = overrun_q;
    strip_number = strip_q;
    mcu_sel      = mcu_q;
    out_data     = coef_data;
  end

endmodule

// File: tb/tb_strip_dct_scheduler.sv
// tb/tb_strip_dct_scheduler.sv - directed vectors and corner sequences for strip_dct_scheduler
module tb_strip_dct_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        strip_ready;
  logic        capture_en;
  logic [4:0]  strip_number;
  logic [4:0]  mcu_sel;
  logic        dct_start;
  logic        dct_done;
  logic [5:0]  coef_idx;
  logic [31:0] coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_eof;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  logic dct_auto = 1'b0;
  logic dct_done_man = 1'b0;
  logic dct_done_auto = 1'b0;
  int   dct_lat = 1;
  int   dct_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  strip_dct_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .strip_ready  (strip_ready),
    .capture_en   (capture_en),
    .strip_number (strip_number),
    .mcu_sel      (mcu_sel),
    .dct_start    (dct_start),
    .dct_done     (dct_done),
    .coef_idx     (coef_idx),
    .coef_data    (coef_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_eof      (out_eof),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  function automatic logic [31:0] word_of(int s, int m, int i);
    return {s[4:0], m[4:0], 16'hA5C3, i[5:0]};
  endfunction

  assign coef_data = word_of(int'(strip_number), int'(mcu_sel), int'(coef_idx));
  assign dct_done  = dct_auto ? dct_done_auto : dct_done_man;

  // DCT stand-in: done rises dct_lat cycles after dct_start and holds until the next start.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      dct_done_auto = 1'b0;
      dct_cnt = 0;
    end else if (dct_start) begin
      dct_done_auto = 1'b0;
      dct_cnt = dct_lat;
    end else if (dct_cnt > 0) begin
      dct_cnt--;
      if (dct_cnt == 0) dct_done_auto = 1'b1;
    end
  end

  function automatic logic [23:0] obs();
    return {capture_en, dct_start, out_valid, out_last, out_eof, busy, frame_done, overrun,
            strip_number, mcu_sel, coef_idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic       ab;
    logic       sr;
    logic       dd;
    logic       rdy;
    logic [7:0] flags;
    logic [4:0] strip;
    logic [4:0] mcu;
    logic [5:0] idx;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int exp_idx;
    logic stalled;
    logic seen_valid;
    logic [31:0] held;
    int words, lasts, eofs, eof_misplaced, order_err, fd_cnt, fd_cyc, last_acc_cyc;
    int ds_first, ds_second;
    int es, em, ei;

    // flags = {capture_en, dct_start, out_valid, out_last, out_eof, busy, frame_done, overrun}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, 5'd0, 5'd0, 6'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00000001, 5'd0, 5'd0, 6'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00000001, 5'd0, 5'd0, 6'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10000100, 5'd0, 5'd0, 6'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10000100, 5'd0, 5'd0, 6'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b10000100, 5'd0, 5'd0, 6'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b01000100, 5'd0, 5'd0, 6'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00000100, 5'd0, 5'd0, 6'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000100, 5'd0, 5'd0, 6'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00100100, 5'd0, 5'd0, 6'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00100100, 5'd0, 5'd0, 6'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b00100100, 5'd0, 5'd0, 6'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b00100101, 5'd0, 5'd0, 6'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'b00000001, 5'd0, 5'd0, 6'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10000100, 5'd0, 5'd0, 6'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b00000000, 5'd0, 5'd0, 6'd0};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    strip_ready = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("reset_state", 32'(obs()), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      start        = vecs[i].st;
      abort        = vecs[i].ab;
      strip_ready  = vecs[i].sr;
      dct_done_man = vecs[i].dd;
      out_ready    = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), 32'(obs()),
            32'({vecs[i].flags, vecs[i].strip, vecs[i].mcu, vecs[i].idx}));
    end
    start = 1'b0;
    abort = 1'b0;
    strip_ready = 1'b0;
    dct_done_man = 1'b0;
    out_ready = 1'b0;
    step();

    // Reset asserted mid-STREAM at coefficient 17.
    dct_auto = 1'b1;
    dct_lat = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    strip_ready = 1'b1;
    step();
    strip_ready = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) step();
    check("a_reach_stream", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    repeat (17) step();
    check("a_idx17", 32'(coef_idx), 32'd17);
    #2;
    reset = 1'b1;
    #1;
    check("a_async_reset", 32'(obs()), 32'h0);
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("a_restart", 32'(obs()), 32'({8'b10000100, 5'd0, 5'd0, 6'd0}));

    // Early dct_done in the DCT_START cycle must be ignored; real done after a long latency.
    dct_auto = 1'b0;
    dct_done_man = 1'b0;
    strip_ready = 1'b1;
    step();
    strip_ready = 1'b0;
    check("d_dct_start", 32'(dct_start), 32'h1);
    dct_done_man = 1'b1;
    step();
    dct_done_man = 1'b0;
    check("d_early_pulse_ignored", 32'({dct_start, out_valid, busy}), 32'b001);
    seen_valid = 1'b0;
    repeat (8) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("d_no_stream_before_done", 32'(seen_valid), 32'h0);
    dct_done_man = 1'b1;
    step();
    check("d_stream_after_done", 32'({out_valid, coef_idx}), 32'({1'b1, 6'd0}));

    // One MCU under random backpressure.
    exp_idx = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 2000 && exp_idx < 64; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (stalled) check("b_hold", out_data, held);
      if (out_ready) begin
        check("b_word", out_data, word_of(0, 0, exp_idx));
        check("b_last", 32'({out_valid, out_last}), 32'({1'b1, exp_idx == 63}));
        exp_idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data;
      end
      step();
    end
    check("b_count", 32'(exp_idx), 32'd64);
    check("b_next_mcu", 32'({dct_start, out_valid, mcu_sel, coef_idx}),
          32'({1'b1, 1'b0, 5'd1, 6'd0}));
    out_ready = 1'b0;
    dct_done_man = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'(obs()), 32'h0);

    // Full frame, no backpressure, DCT latency 1.
    dct_auto = 1'b1;
    dct_lat = 1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    words = 0; lasts = 0; eofs = 0; eof_misplaced = 0; order_err = 0;
    fd_cnt = 0; fd_cyc = -1; last_acc_cyc = -1; ds_first = -1; ds_second = -1;
    es = 0; em = 0; ei = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      strip_ready = capture_en;
      if (dct_start) begin
        if (ds_first < 0) ds_first = cyc;
        else if (ds_second < 0) ds_second = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (out_data !== word_of(es, em, ei)) order_err++;
        if (out_last !== (ei == 63)) order_err++;
        if (out_last) lasts++;
        if (out_eof) begin
          eofs++;
          if (words != 50175) eof_misplaced++;
        end
        words++;
        last_acc_cyc = cyc;
        ei++;
        if (ei == 64) begin
          ei = 0;
          em++;
          if (em == 28) begin
            em = 0;
            es++;
          end
        end
      end else if (out_eof) begin
        eof_misplaced++;
      end
      if (fd_cnt > 0 && cyc > fd_cyc + 2) break;
      step();
    end
    strip_ready = 1'b0;
    check("c_words", 32'(words), 32'd50176);
    check("c_lasts", 32'(lasts), 32'd784);
    check("c_eofs", 32'(eofs), 32'd1);
    check("c_eof_position", 32'(eof_misplaced), 32'd0);
    check("c_order", 32'(order_err), 32'd0);
    check("c_frame_done_count", 32'(fd_cnt), 32'd1);
    check("c_frame_done_delay", 32'(fd_cyc - last_acc_cyc), 32'd1);
    check("c_mcu_period", 32'(ds_second - ds_first), 32'd66);
    check("c_end_state", 32'(obs()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
